// File: rtl/ps2_text_term_ctrl.sv
// Text-terminal controller: buffers PS/2 ASCII bytes, tracks a cursor and writes glyphs into a
// circular COLS x ROWS character RAM, clearing the whole screen on reset and each newly exposed row.
module ps2_text_term_ctrl #(
    parameter int COLS       = 70,
    parameter int ROWS       = 30,
    parameter int FIFO_DEPTH = 4,
    parameter int TAB_W      = 4,
    localparam int ADDR_W    = $clog2(COLS*ROWS),
    localparam int CW        = $clog2(COLS),
    localparam int RW        = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_ascii,
    input  logic              in_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [CW-1:0]     cur_col,
    output logic [RW-1:0]     cur_row,
    output logic [RW-1:0]     top_row,
    output logic              busy,
    output logic              overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(COLS*ROWS-1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [CW-1:0]     COL_LAST  = CW'(COLS-1);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS-1);
    localparam logic [RW:0]       ROWS_E    = (RW+1)'(ROWS);
    localparam logic [CW:0]       COLS_E    = (CW+1)'(COLS);
    localparam logic [CW:0]       TAB_E     = (CW+1)'(TAB_W);
    localparam logic [7:0]        SPACE     = 8'h20;

    typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;

    state_t            state, state_n;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr;
    logic              empty, full, push, pop;
    logic [7:0]        head;
    logic [ADDR_W-1:0] clr_addr, clr_addr_n, wr_addr_n, row_addr, prev_row_addr;
    logic [CW-1:0]     clr_col, clr_col_n, col_n;
    logic [RW-1:0]     row_n, top_n, phys, phys_prev;
    logic [RW:0]       psum;
    logic [CW:0]       tab_nxt;
    logic [7:0]        wr_data_n;
    logic              wr_en_n, do_nl;

    // Byte FIFO: pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push  = in_valid && !full;
    assign head  = fifo_mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= in_ascii;
    end

    // Physical RAM row of the cursor and of the row above it, with wrap.
    assign psum          = {1'b0, top_row} + {1'b0, cur_row};
    assign phys          = (psum >= ROWS_E) ? RW'(psum - ROWS_E) : RW'(psum);
    assign phys_prev     = (phys == '0) ? ROW_LAST : phys - RW'(1);
    assign row_addr      = ADDR_W'(phys) * COLS_A;
    assign prev_row_addr = ADDR_W'(phys_prev) * COLS_A;
    assign tab_nxt       = {1'b0, cur_col} + TAB_E - ({1'b0, cur_col} % TAB_E);

    always_comb begin
        state_n    = state;
        col_n      = cur_col;
        row_n      = cur_row;
        top_n      = top_row;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        clr_addr_n = clr_addr;
        clr_col_n  = clr_col;
        pop        = 1'b0;
        do_nl      = 1'b0;
        case (state)
            CLR_ALL: begin
                wr_en_n    = 1'b1;
                wr_addr_n  = clr_addr;
                wr_data_n  = SPACE;
                clr_addr_n = clr_addr + ADDR_W'(1);
                if (clr_addr == CELL_LAST) state_n = IDLE;
            end
            CLR_ROW: begin
                wr_en_n    = 1'b1;
                wr_addr_n  = clr_addr;
                wr_data_n  = SPACE;
                clr_addr_n = clr_addr + ADDR_W'(1);
                clr_col_n  = clr_col + CW'(1);
                if (clr_col == COL_LAST) state_n = IDLE;
            end
            default: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head >= 8'h20 && head <= 8'h7E) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = row_addr + ADDR_W'(cur_col);
                        wr_data_n = head;
                        if (cur_col == COL_LAST) do_nl = 1'b1;
                        else col_n = cur_col + CW'(1);
                    end else if (head == 8'h0D || head == 8'h0A) begin
                        do_nl = 1'b1;
                    end else if (head == 8'h08) begin
                        if (cur_col != '0) begin
                            col_n     = cur_col - CW'(1);
                            wr_en_n   = 1'b1;
                            wr_addr_n = row_addr + ADDR_W'(cur_col - CW'(1));
                            wr_data_n = SPACE;
                        end else if (cur_row != '0) begin
                            row_n     = cur_row - RW'(1);
                            col_n     = COL_LAST;
                            wr_en_n   = 1'b1;
                            wr_addr_n = prev_row_addr + ADDR_W'(COL_LAST);
                            wr_data_n = SPACE;
                        end
                    end else if (head == 8'h09) begin
                        if (tab_nxt >= COLS_E) do_nl = 1'b1;
                        else col_n = CW'(tab_nxt);
                    end
                end
            end
        endcase
        // Newline at the bottom scrolls: the old top row becomes the new bottom and is cleared.
        if (do_nl) begin
            col_n = '0;
            if (cur_row != ROW_LAST) begin
                row_n = cur_row + RW'(1);
            end else begin
                top_n      = (top_row == ROW_LAST) ? '0 : top_row + RW'(1);
                state_n    = CLR_ROW;
                clr_addr_n = ADDR_W'(top_row) * COLS_A;
                clr_col_n  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLR_ALL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cur_col  <= '0;
            cur_row  <= '0;
            top_row  <= '0;
            clr_addr <= '0;
            clr_col  <= '0;
            busy     <= 1'b1;
        end else begin
            state    <= state_n;
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
            overflow <= overflow | (in_valid & full);
            wr_en    <= wr_en_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            cur_col  <= col_n;
            cur_row  <= row_n;
            top_row  <= top_n;
            clr_addr <= clr_addr_n;
            clr_col  <= clr_col_n;
            // Lags the state by a cycle so it stays high through the final clear write.
            busy     <= (state != IDLE);
        end
    end
endmodule

// File: tb/tb_ps2_text_term_ctrl.sv
// Scoreboard bench for ps2_text_term_ctrl: a cursor/screen model predicts every RAM write.
module tb_ps2_text_term_ctrl;
    localparam int COLS = 70, ROWS = 30, FIFO_DEPTH = 4, TAB_W = 4;
    localparam int NCELL = COLS*ROWS;

    typedef struct { int addr; int data; } exp_t;

    logic        clk = 0, rst = 1, in_valid = 0;
    logic [7:0]  in_ascii = 0;
    logic        wr_en, busy, overflow;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row, top_row;

    ps2_text_term_ctrl #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(FIFO_DEPTH), .TAB_W(TAB_W)) dut (
        .clk(clk), .rst(rst), .in_ascii(in_ascii), .in_valid(in_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cur_col(cur_col),
        .cur_row(cur_row), .top_row(top_row), .busy(busy), .overflow(overflow));

    always #5 clk = ~clk;

    int   n_chk = 0, n_pass = 0, cyc = 0, last_wr_cyc = 0, run = 0, last_run = 0;
    int   m_col = 0, m_row = 0, m_top = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    // Reference model: screen rules in plain integer arithmetic.
    function automatic int phys_of(input int r);
        return (m_top + r) % ROWS;
    endfunction

    task automatic m_write(input int addr, input int data);
        exp_t e;
        e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic m_newline();
        m_col = 0;
        if (m_row < ROWS-1) m_row++;
        else begin
            for (int c = 0; c < COLS; c++) m_write(m_top*COLS + c, 32);
            m_top = (m_top + 1) % ROWS;
        end
    endtask

    task automatic model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_write(phys_of(m_row)*COLS + m_col, int'(b));
            m_col++;
            if (m_col == COLS) m_newline();
        end else if (b == 8'h0D || b == 8'h0A) begin
            m_newline();
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_write(phys_of(m_row)*COLS + m_col, 32);
            end else if (m_row > 0) begin
                m_row--;
                m_col = COLS-1;
                m_write(phys_of(m_row)*COLS + m_col, 32);
            end
        end else if (b == 8'h09) begin
            m_col = (m_col / TAB_W + 1) * TAB_W;
            if (m_col >= COLS) m_newline();
        end
    endtask

    // Monitor: every DUT write must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: addr %0d data %0h, none expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
            end
            last_wr_cyc = cyc;
        end
        if (rst) run = 0;
        else if (busy === 1'b1) run++;
        else if (run > 0) begin last_run = run; run = 0; end
    end

    task automatic send(input logic [7:0] b, input bit modeled);
        in_ascii = b; in_valid = 1;
        if (modeled) model_apply(b);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_cur_col", int'(cur_col), 0);
        check("rst_cur_row", int'(cur_row), 0);
        check("rst_top_row", int'(top_row), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 1);
        exp_q.delete();
        for (int a = 0; a < NCELL; a++) m_write(a, 32);
        m_col = 0; m_row = 0; m_top = 0;
        rst = 0;
    endtask

    task automatic wait_clear();
        int n = 0;
        while (busy && n < 5000) begin @(posedge clk); #1; n++; end
        check("clear_done", int'(busy), 0);
        check("busy_fall_cycle", cyc, last_wr_cyc + 1);
        check("clear_drained", exp_q.size(), 0);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 6000 && quiet < 10; i++) begin
            @(posedge clk); #1;
            if (!busy) quiet++; else quiet = 0;
        end
        check("idle_reached", int'(quiet >= 10), 1);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, int'(cur_col), m_col);
        check({tag, "_row"}, int'(cur_row), m_row);
        check({tag, "_top"}, int'(top_row), m_top);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] b;
        int k, n;
        do_reset();
        wait_clear();

        // Backspace at home: no write, no move.
        send(8'h08, 1);
        wait_idle();
        check_cursor("bs_home");

        // 'A' latency: strobe cycle t, write visible at t+2.
        send(8'h41, 1);
        check("lat_t1_wr_en", int'(wr_en), 0);
        @(posedge clk); #1;
        check("lat_t2_wr_en", int'(wr_en), 1);
        check("lat_t2_addr", int'(wr_addr), 0);
        check("lat_t2_data", int'(wr_data), 8'h41);
        check("lat_t2_col", int'(cur_col), 1);

        // 70 more chars wrap onto row 1.
        for (int i = 0; i < 70; i++) send(8'($urandom_range(33, 126)), 1);
        wait_idle();
        check("wrap_row", int'(cur_row), 1);
        check("wrap_col", int'(cur_col), 1);
        check_cursor("wrap");

        // Backspace across the row boundary.
        send(8'h08, 1);
        send(8'h08, 1);
        wait_idle();
        check("bs_up_row", int'(cur_row), 0);
        check("bs_up_col", int'(cur_col), 69);
        check_cursor("bs_up");

        // Tab from column 2.
        send(8'h0D, 1); send(8'h61, 1); send(8'h62, 1); send(8'h09, 1);
        wait_idle();
        check("tab_col", int'(cur_col), 4);
        check_cursor("tab");

        // Scroll from the bottom row with chars queued behind the clear.
        while (m_row < ROWS-1) send(8'h0A, 1);
        send(8'h0D, 1); send(8'h78, 1); send(8'h79, 1); send(8'h7A, 1);
        wait_idle();
        check("scroll_top", int'(top_row), 1);
        check("scroll_busy_len", last_run, COLS);
        check_cursor("scroll");

        // Overflow: five strobes while a row clear holds the FIFO.
        send(8'h0D, 1);
        n = 0;
        while (!busy && n < 20) begin @(posedge clk); #1; n++; end
        check("ovf_busy_seen", int'(busy), 1);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(33, 126)), i < FIFO_DEPTH);
        wait_idle();
        check("ovf_set", int'(overflow), 1);
        check_cursor("ovf");
        send(8'h51, 1);
        wait_idle();
        check("ovf_sticky", int'(overflow), 1);

        // Reset in the middle of a full clear restarts it from address 0.
        do_reset();
        repeat (500) @(posedge clk);
        do_reset();
        wait_clear();

        // Random mix of printables, control codes and junk.
        for (int i = 0; i < 400; i++) begin
            n = 0;
            while (busy && n < 200) begin @(posedge clk); #1; n++; end
            k = $urandom_range(0, 99);
            if (k < 70)      b = 8'($urandom_range(32, 126));
            else if (k < 78) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
            else if (k < 88) b = 8'h08;
            else if (k < 95) b = 8'h09;
            else begin
                case ($urandom_range(0, 4))
                    0: b = 8'h00; 1: b = 8'h1B; 2: b = 8'h7F; 3: b = 8'h80; default: b = 8'hFF;
                endcase
            end
            send(b, 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        wait_idle();
        check("rand_overflow", int'(overflow), 0);
        check_cursor("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
